// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory controller:
// RV32 load/store funct3 encodings, FSM states and a counter sizing helper.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Width of a counter that must hold 0..wait_cyc-1. Never narrower than one bit.
    function automatic int cnt_width(input int wait_cyc);
        return (wait_cyc <= 1) ? 1 : $clog2(wait_cyc);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32 loads and stores: byte enables,
// lane-replicated store data, extended load data and access-fault flags.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    assign half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Decode access size into lane enables, steered data and fault flags.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        be_o        = 4'b0000;
        wword_o     = 32'h0;
        load_data_o = 32'h0;
        misalign_o  = 1'b0;
        illegal_o   = we_i ? (funct3_i > F3_W)
                           : (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111);
        case (funct3_i)
            F3_B: begin
                be_o        = 4'b0001 << lane_i;
                wword_o     = {4{wdata_i[7:0]}};
                load_data_o = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_BU: begin
                load_data_o = {24'h0, byte_sel};
            end
            F3_H: begin
                misalign_o  = lane_i[0];
                be_o        = lane_i[1] ? 4'b1100 : 4'b0011;
                wword_o     = {2{wdata_i[15:0]}};
                load_data_o = {{16{half_sel[15]}}, half_sel};
            end
            F3_HU: begin
                misalign_o  = lane_i[0];
                load_data_o = {16'h0, half_sel};
            end
            F3_W: begin
                misalign_o  = |lane_i;
                be_o        = 4'b1111;
                wword_o     = wdata_i;
                load_data_o = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed RV32 data memory behind a valid/ready request/response
// handshake with a fixed number of wait states. The access commits (write or
// read) on the edge that enters RESP; the response is held until accepted.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_CYC    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = cnt_width(WAIT_CYC);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              commit;

    logic [31:0]       mem_q [DEPTH_WORDS];

    // In IDLE the access can commit on the accepting edge (no wait states),
    // so the live request is used there; otherwise the latched copy.
    logic              op_we;
    logic [2:0]        op_f3;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic [IDX_W-1:0]  op_idx;
    logic              op_oor, op_misalign, op_illegal, op_err, mem_we;
    logic [3:0]        op_be;
    logic [31:0]       op_wword, op_load;

    assign op_we    = (state_q == IDLE) ? req_we     : we_q;
    assign op_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
    assign op_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    assign op_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
    assign op_idx   = op_addr[IDX_W+1:2];
    assign op_oor   = |op_addr[ADDR_W-1:IDX_W+2];
    assign op_err   = op_oor | op_misalign | op_illegal;
    assign mem_we   = commit & op_we & ~op_err;

    dmem_lane_align u_lane_align (
        .we_i        (op_we),
        .funct3_i    (op_f3),
        .lane_i      (op_addr[1:0]),
        .wdata_i     (op_wdata),
        .rword_i     (mem_q[op_idx]),
        .be_o        (op_be),
        .wword_o     (op_wword),
        .load_data_o (op_load),
        .misalign_o  (op_misalign),
        .illegal_o   (op_illegal)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state, wait counter, commit strobe and response capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = '0;
                    if (WAIT_CYC > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(WAIT_CYC - 1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rsp_err_d   = op_err;
            rsp_rdata_d = (op_err || op_we) ? 32'h0 : op_load;
        end
    end

    // Control state, request latch and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Byte-lane write into the storage array on the commit edge.
    // NOTE: the array is deliberately outside the reset domain; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be[b]) mem_q[op_idx][8*b +: 8] <= op_wword[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-array reference model computes
// each expected response when the request is driven; responses are popped and
// compared as the DUT produces them, along with latency and hold behaviour.
module tb_data_mem_ctrl;

    localparam int ADDR_W   = 32;
    localparam int DEPTH    = 64;
    localparam int WAIT_CYC = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int   n_vec = 0;
    int   n_miscmp = 0;
    exp_t sb[$];
    logic [7:0] mdl [int];

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .WAIT_CYC(WAIT_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: size from funct3[1:0], alignment by modulo, little-endian byte gather.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int size;
        logic [31:0] v;
        rd = 32'h0;
        er = 1'b0;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        if (size == 0) er = 1'b1;
        else begin
            if (f3[2] && (we || size == 4)) er = 1'b1;
            if ((addr % size) != 0) er = 1'b1;
        end
        if ((addr >> 2) >= DEPTH) er = 1'b1;
        if (er) return;
        if (we) begin
            for (int i = 0; i < size; i++) mdl[int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[int'(addr) + i];
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endfunction

    // Request inputs must be ignored while the block is busy.
    task automatic scramble();
        req_valid  = 1'($urandom_range(0, 1));
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] got, output logic got_err);
        exp_t e;
        int   lat;
        model(we, f3, addr, wdata, e.rdata, e.err);
        sb.push_back(e);
        got = 32'h0;
        got_err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_miscmp++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        scramble();
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_miscmp++; $display("FAIL req_ready_busy: got %b want 0", req_ready);
        end
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk); scramble();
        end
        n_vec++;
        if (lat != WAIT_CYC + 1) begin
            n_miscmp++; $display("FAIL latency: got %0d edges want %0d", lat, WAIT_CYC + 1);
        end
        if (rsp_valid !== 1'b1) begin
            void'(sb.pop_front());
            req_valid = 1'b0;
            return;
        end
        got = rsp_rdata;
        got_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk); scramble();
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== got || rsp_err !== got_err || req_ready !== 1'b0) begin
                n_miscmp++;
                $display("FAIL hold_stable: cyc %0d valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                         h, rsp_valid, rsp_rdata, rsp_err, req_ready, got, got_err);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        e = sb.pop_front();
        n_vec++;
        if (got !== e.rdata || got_err !== e.err) begin
            n_miscmp++;
            $display("FAIL response addr=%h f3=%b we=%b: got rdata=%h err=%b want rdata=%h err=%b",
                     addr, f3, we, got, got_err, e.rdata, e.err);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_miscmp++;
            $display("FAIL after_handshake: ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_miscmp++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_round_trip();
        logic [31:0] d; logic er;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, d, er);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, d, er);
        n_vec++;
        if (d !== 32'hDEADBEEF || er !== 1'b0) begin
            n_miscmp++; $display("FAIL lw_roundtrip: got %h/%b want deadbeef/0", d, er);
        end
    endtask

    task automatic test_byte();
        logic [31:0] d; logic er;
        do_req(1'b1, 3'b010, 32'h10, 32'h11223344, 0, d, er);
        do_req(1'b1, 3'b000, 32'h13, 32'hABCDEF80, 0, d, er);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, d, er);
        n_vec++;
        if (d !== 32'h80223344) begin
            n_miscmp++; $display("FAIL sb_merge: got %h want 80223344", d);
        end
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0, d, er);
        n_vec++;
        if (d !== 32'hFFFFFF80) begin
            n_miscmp++; $display("FAIL lb_sext: got %h want ffffff80", d);
        end
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 0, d, er);
        n_vec++;
        if (d !== 32'h00000080) begin
            n_miscmp++; $display("FAIL lbu_zext: got %h want 00000080", d);
        end
        do_req(1'b0, 3'b000, 32'h11, 32'h0, 0, d, er);
    endtask

    task automatic test_half();
        logic [31:0] d; logic er;
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 0, d, er);
        n_vec++;
        if (d !== 32'hFFFF8022) begin
            n_miscmp++; $display("FAIL lh_sext: got %h want ffff8022", d);
        end
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 0, d, er);
        n_vec++;
        if (d !== 32'h00008022) begin
            n_miscmp++; $display("FAIL lhu_zext: got %h want 00008022", d);
        end
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 0, d, er);
        do_req(1'b1, 3'b001, 32'h12, 32'h0000A5A5, 0, d, er);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, d, er);
    endtask

    task automatic test_misaligned_illegal();
        logic [31:0] d; logic er;
        do_req(1'b1, 3'b010, 32'h12, 32'h0BADF00D, 0, d, er);
        n_vec++;
        if (er !== 1'b1 || d !== 32'h0) begin
            n_miscmp++; $display("FAIL sw_misaligned: got %h/%b want 0/1", d, er);
        end
        do_req(1'b0, 3'b001, 32'h11, 32'h0, 0, d, er);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, d, er);
        do_req(1'b0, 3'b110, 32'h10, 32'h0, 0, d, er);
        do_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, d, er);
        do_req(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 0, d, er);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, d, er);
        n_vec++;
        if (d !== 32'hA5A53344) begin
            n_miscmp++; $display("FAIL unchanged_after_err: got %h want a5a53344", d);
        end
    endtask

    task automatic test_range_backpressure();
        logic [31:0] d; logic er;
        do_req(1'b0, 3'b010, DEPTH * 4, 32'h0, 5, d, er);
        n_vec++;
        if (er !== 1'b1 || d !== 32'h0) begin
            n_miscmp++; $display("FAIL out_of_range: got %h/%b want 0/1", d, er);
        end
        do_req(1'b1, 3'b010, DEPTH * 4 - 4, 32'hCAFEF00D, 2, d, er);
        do_req(1'b0, 3'b010, DEPTH * 4 - 4, 32'h0, 3, d, er);
        do_req(1'b1, 3'b000, DEPTH * 4 + 1, 32'h0, 0, d, er);
        do_req(1'b0, 3'b010, 32'h80000000, 32'h0, 0, d, er);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic er;
        for (int w = 0; w < 8; w++) do_req(1'b1, 3'b010, 32'(w * 4), $urandom, 0, d, er);
        for (int n = 0; n < 24; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 31)),
                   $urandom, $urandom_range(0, 2), d, er);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d; logic er;
        do_req(1'b1, 3'b010, 32'h20, 32'h55AA55AA, 0, d, er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_miscmp++;
            $display("FAIL reset_mid_wait: ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, d, er);
        n_vec++;
        if (d !== 32'h55AA55AA) begin
            n_miscmp++; $display("FAIL store_discarded: got %h want 55aa55aa", d);
        end
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_byte();
        test_half();
        test_misaligned_illegal();
        test_range_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        n_vec++;
        if (sb.size() != 0) begin
            n_miscmp++; $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressed data memory for the RISC-V core's load/store path. Successor to the flat word-indexed data memory.
- Adds RV32 access sizes (B/H/W, signed and unsigned loads) and byte-lane writes.
- Adds misalignment, range and illegal-size error reporting.
- Adds a valid/ready request/response handshake with configurable wait-state latency, so it can sit behind a multi-cycle or pipelined LSU.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 512, number of 32-bit words. Power of two, at least 4.
- WAIT_CYC, 0, extra wait cycles between request acceptance and response. Range 0..15.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, a request is presented.
- req_ready, output, 1, the block can accept a request.
- req_we, input, 1, 1 = store, 0 = load.
- req_funct3, input, 3, RISC-V funct3 access size and sign.
- req_addr, input, ADDR_W, byte address.
- req_wdata, input, 32, store data, right-aligned.
- rsp_valid, output, 1, response is available.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_rdata, output, 32, load result, already extended. 0 for stores and errors.
- rsp_err, output, 1, access faulted.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. FSM=IDLE, wait counter=0.
- Reset does not clear the memory array. Array contents are X until written.
- FSM states:
  - IDLE: req_ready=1. When req_valid is high, latch we, funct3, addr and wdata. Go to WAIT if WAIT_CYC>0, else RESP.
  - WAIT: req_ready=0. Counter counts 0..WAIT_CYC-1, then go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1. On the handshake, go to IDLE.
- Back-to-back: req_ready rises the cycle after the response handshake. No overlap of requests.
- Latency: rsp_valid rises WAIT_CYC+1 cycles after the accepting edge.
- Commit point: the store write and the load read both occur on the edge entering RESP. A load issued after a store therefore sees the new data.
- Word index = addr[ADDR_W-1:2]. Byte lane = addr[1:0].
- Loads:
  - LB (000): sign-extend the selected byte.
  - LBU (100): zero-extend the selected byte.
  - LH (001) / LHU (101): half selected by addr[1], sign- or zero-extended.
  - LW (010): full word.
- Stores:
  - SB (000): write wdata[7:0] to the lane given by addr[1:0].
  - SH (001): write wdata[15:0] to the half given by addr[1].
  - SW (010): write the full word.
  - Unselected bytes are preserved.
- Errors set rsp_err=1, force rsp_rdata=0 and suppress the write. Latency is unchanged. Error causes:
  - Misaligned: H access with addr[0]=1; W access with addr[1:0]≠0.
  - Out of range: word index ≥ DEPTH_WORDS.
  - Illegal size: load funct3 ∈ {011,110,111}; store funct3 > 010.
- Input changes: changes on req_* while req_ready=0 are ignored.
- Reset mid-operation (WAIT or RESP): return to IDLE. A store still in WAIT is discarded. A store already committed stays written.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum {IDLE, WAIT, RESP}.
  - WAIT counter width function (clog2).
- Sub-module dmem_lane_align: combinational. Takes funct3, addr[1:0], wdata and the raw read word. Produces:
  - 4-bit byte-enable,
  - lane-shifted write word,
  - extended load data,
  - misalign and illegal flags.

Test Plan:
- Reset and idle: assert rst_n=0 mid-WAIT with a pending SW → after release, req_ready=1, rsp_valid=0, and the target word is unchanged.
- Full-word round trip: SW 0xDEADBEEF to addr 0x10, then LW 0x10 with WAIT_CYC=3 → rsp_valid rises 4 cycles after acceptance, rdata=0xDEADBEEF, err=0.
- Byte store and loads: SB 0x80 at 0x13 over 0x11223344 → word becomes 0x80223344. LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080.
- Halfword loads: LH 0x12 on 0x80223344 → 0xFFFF8022; LHU → 0x00008022.
- Misaligned store: SW at 0x12 → err=1, rdata=0, memory unchanged. Same for LH 0x11.
- Range and backpressure: LW at byte address DEPTH_WORDS*4 → err=1. Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_err stay stable and req_ready stays 0.
